// File: rtl/cache_wb_buffer_pkg.sv
// rtl/cache_wb_buffer_pkg.sv - shared defaults and sizing helper for the writeback buffer
package cache_wb_buffer_pkg;

  localparam int DEF_NUM_ENTRIES     = 4;
  localparam int DEF_LINE_SIZE       = 16;
  localparam int DEF_LINE_ADDR_WIDTH = 26;
  localparam int DEF_MEM_TAG_WIDTH   = 4;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_wb_buffer_if.sv
// rtl/cache_wb_buffer_if.sv - eviction, memory-request and lookup signals of the writeback buffer
interface cache_wb_buffer_if #(
  parameter int LINE_SIZE       = cache_wb_buffer_pkg::DEF_LINE_SIZE,
  parameter int LINE_ADDR_WIDTH = cache_wb_buffer_pkg::DEF_LINE_ADDR_WIDTH,
  parameter int MEM_TAG_WIDTH   = cache_wb_buffer_pkg::DEF_MEM_TAG_WIDTH
);

  logic                       evict_valid;
  logic [LINE_ADDR_WIDTH-1:0] evict_addr;
  logic [LINE_SIZE*8-1:0]     evict_data;
  logic [LINE_SIZE-1:0]       evict_byteen;
  logic                       evict_ready;

  logic                       mem_req_valid;
  logic                       mem_req_rw;
  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_SIZE*8-1:0]     mem_req_data;
  logic [LINE_SIZE-1:0]       mem_req_byteen;
  logic [MEM_TAG_WIDTH-1:0]   mem_req_tag;
  logic                       mem_req_ready;

  logic [LINE_ADDR_WIDTH-1:0] lookup_addr;
  logic                       lookup_hit;
  logic                       empty;

  // slave is the buffer itself; master is the bank/memory side driving it
  modport slave (
    input  evict_valid, evict_addr, evict_data, evict_byteen,
    output evict_ready,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
    input  mem_req_ready,
    input  lookup_addr,
    output lookup_hit, empty
  );

  modport master (
    output evict_valid, evict_addr, evict_data, evict_byteen,
    input  evict_ready,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
    output mem_req_ready,
    output lookup_addr,
    input  lookup_hit, empty
  );

endinterface

// File: rtl/cache_wb_entry_match.sv
// rtl/cache_wb_entry_match.sv - per-entry address comparator array producing a match vector
module cache_wb_entry_match #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_WIDTH  = 26
) (
  input  logic [NUM_ENTRIES-1:0]                 i_valid,
  input  logic [NUM_ENTRIES-1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0]                  i_lookup_addr,
  output logic [NUM_ENTRIES-1:0]                 o_match
);

  always_comb begin
    o_match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      o_match[i] = i_valid[i] && (i_addr[i] == i_lookup_addr);
    end
  end

endmodule

// File: rtl/cache_wb_buffer.sv
// rtl/cache_wb_buffer.sv - per-bank writeback FIFO feeding memory write requests
module cache_wb_buffer import cache_wb_buffer_pkg::*; #(
  parameter int BANK_ID         = 0,
  parameter int NUM_ENTRIES     = DEF_NUM_ENTRIES,
  parameter int LINE_SIZE       = DEF_LINE_SIZE,
  parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
  parameter int MEM_TAG_WIDTH   = DEF_MEM_TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_wb_buffer_if.slave       bus
);

  localparam int PTR_W  = ptr_width(NUM_ENTRIES);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = LINE_SIZE * 8;

  logic [PTR_W-1:0]                            r_head;
  logic [PTR_W-1:0]                            r_tail;
  logic [CNT_W-1:0]                            r_count;
  logic [NUM_ENTRIES-1:0]                      r_valid;
  logic [NUM_ENTRIES-1:0][LINE_ADDR_WIDTH-1:0] r_addr;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0]          r_data;
  logic [NUM_ENTRIES-1:0][LINE_SIZE-1:0]       r_byteen;

  logic                   w_full;
  logic                   w_dirty;
  logic                   w_evict_ready;
  logic                   w_enq;
  logic                   w_req_valid;
  logic                   w_deq;
  logic [NUM_ENTRIES-1:0] w_match;
  logic                   w_evict_match;

  assign w_full        = (r_count == CNT_W'(NUM_ENTRIES));
  assign w_dirty       = |bus.evict_byteen;
  // ready ignores a same-cycle dequeue so a freed slot is only usable next cycle
  assign w_evict_ready = !w_full && !reset;
  assign w_enq         = bus.evict_valid && w_evict_ready && w_dirty;
  assign w_req_valid   = (r_count != '0) && !reset;
  assign w_deq         = w_req_valid && bus.mem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // payload storage needs no reset; only the valid bits qualify it
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail]   <= bus.evict_addr;
      r_data[r_tail]   <= bus.evict_data;
      r_byteen[r_tail] <= bus.evict_byteen;
    end
  end

  cache_wb_entry_match #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_WIDTH  (LINE_ADDR_WIDTH)
  ) u_match (
    .i_valid       (r_valid),
    .i_addr        (r_addr),
    .i_lookup_addr (bus.lookup_addr),
    .o_match       (w_match)
  );

  assign w_evict_match = bus.evict_valid && w_dirty && (bus.evict_addr == bus.lookup_addr);

  assign bus.evict_ready    = w_evict_ready;
  assign bus.mem_req_valid  = w_req_valid;
  assign bus.mem_req_rw     = 1'b1;
  assign bus.mem_req_addr   = r_addr[r_head];
  assign bus.mem_req_data   = r_data[r_head];
  assign bus.mem_req_byteen = r_byteen[r_head];
  assign bus.mem_req_tag    = MEM_TAG_WIDTH'(r_head);
  assign bus.lookup_hit     = !reset && ((|w_match) || w_evict_match);
  assign bus.empty          = (r_count == '0) || reset;

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset) w_enq |-> !w_full)
    else $error("cache_wb_buffer bank %0d: enqueue while full", BANK_ID);

  a_evict_known: assert property (@(posedge clk) disable iff (reset)
    bus.evict_valid |-> !$isunknown({bus.evict_addr, bus.evict_data, bus.evict_byteen}))
    else $error("cache_wb_buffer bank %0d: X on evict fields", BANK_ID);

endmodule
